arb_mux_reg: RTL and testbench



---
 rtl/arb_mux_if.sv | 26 ++
 rtl/arb_mux_reg.sv | 108 ++++++++++
 tb/tb_arb_mux_reg.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux_reg: K packed request words in, one registered word out.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface arb_mux_if #(
  parameter int N = 4,
  parameter int K = 4
);
  localparam int SW = $clog2(K);

  logic [K*N-1:0] in_data;
  logic [K-1:0]   in_valid;
  logic [K-1:0]   in_ready;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sel;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/arb_mux_reg.sv
// K-input, N-bit arbitrating mux with a registered output stage and valid/ready on every port.
// Round-robin by default; define ARB_MUX_FIXED_PRIORITY_EN for lowest-index-wins priority.
module arb_mux_reg #(
  parameter int N = 4,
  parameter int K = 4
) (
  input logic       clk,
  input logic       rst,
  arb_mux_if.slave  bus
);
  localparam int SW = $clog2(K);

  logic           grant_vld;
  logic [SW-1:0]  grant_idx;
  logic [N-1:0]   grant_data;
  logic           load_en;
  logic           accept;

  logic [N-1:0]   out_data_q,  out_data_d;
  logic [SW-1:0]  out_sel_q,   out_sel_d;
  logic           out_valid_q, out_valid_d;

`ifndef ARB_MUX_FIXED_PRIORITY_EN
  logic [SW-1:0]  ptr_q, ptr_d;
`endif

  // Output register can take a word when empty or when its current word drains now.
  assign load_en = !out_valid_q || bus.out_ready;
  assign accept  = grant_vld && load_en;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
`ifdef ARB_MUX_FIXED_PRIORITY_EN
    for (int i = 0; i < K; i++) begin
      if (!grant_vld && bus.in_valid[i]) begin
        grant_vld  = 1'b1;
        grant_idx  = SW'(i);
        grant_data = bus.in_data[i*N +: N];
      end
    end
`else
    // Two passes emulate the circular scan ptr..K-1 then 0..ptr-1 without a modulo.
    for (int i = 0; i < K; i++) begin
      if (!grant_vld && bus.in_valid[i] && (i >= int'(ptr_q))) begin
        grant_vld  = 1'b1;
        grant_idx  = SW'(i);
        grant_data = bus.in_data[i*N +: N];
      end
    end
    for (int i = 0; i < K; i++) begin
      if (!grant_vld && bus.in_valid[i]) begin
        grant_vld  = 1'b1;
        grant_idx  = SW'(i);
        grant_data = bus.in_data[i*N +: N];
      end
    end
`endif
  end

  assign bus.in_ready = accept ? (K'(1) << grant_idx) : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (accept) begin
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
    end
  end

`ifndef ARB_MUX_FIXED_PRIORITY_EN
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == SW'(K - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
`ifndef ARB_MUX_FIXED_PRIORITY_EN
      ptr_q       <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
`ifndef ARB_MUX_FIXED_PRIORITY_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed self-checking bench for arb_mux_reg (N=8, K=4) with hand-computed expectations.
// Covers reset, round-robin sweep, wrap/skip, backpressure, reset mid-stall and the fixed-priority build.
module tb_arb_mux_reg;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  arb_mux_if #(.N(8), .K(4)) bus ();

  arb_mux_reg #(.N(8), .K(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] val);
    bus.in_data[i*8 +: 8] = val;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    check({tag, "_valid"}, bus.out_valid, v);
    check({tag, "_data"},  bus.out_data,  d);
    check({tag, "_sel"},   bus.out_sel,   s);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'hF;
    bus.in_data   = '0;
    for (int i = 0; i < 4; i++) set_data(i, 8'hA0 + 8'(i));

    // Reset held two edges with every input requesting.
    repeat (2) begin
      tick();
      check_out("reset", 1'b0, 8'h00, 2'd0);
    end
    check("reset_in_ready", bus.in_ready, 4'b0001);
    rst = 1'b0;

`ifndef ARB_MUX_FIXED_PRIORITY_EN
    // Sweep: grants 0,1,2,3,0,1,2 leaves the pointer at 3.
    for (int k = 0; k < 7; k++) begin
      #1 check("rr_in_ready", bus.in_ready, 32'(1 << (k % 4)));
      tick();
      check_out("rr_sweep", 1'b1, 8'hA0 + 8'(k % 4), 2'(k % 4));
    end

    // Wrap and skip: pointer 3, inputs 1 and 3 valid.
    bus.in_valid = 4'b1010;
    #1 check("wrap_in_ready", bus.in_ready, 4'b1000);
    tick();
    check_out("wrap_g3", 1'b1, 8'hA3, 2'd3);
    #1 check("skip_in_ready", bus.in_ready, 4'b0010);
    tick();
    check_out("skip_g1", 1'b1, 8'hA1, 2'd1);
    bus.in_valid = 4'hF;
    #1 check("ptr2_in_ready", bus.in_ready, 4'b0100);

    // Backpressure: load 5C from input 2, then stall for three cycles.
    set_data(2, 8'h5C);
    tick();
    check_out("bp_load", 1'b1, 8'h5C, 2'd2);
    bus.out_ready = 1'b0;
    repeat (3) begin
      #1 check("bp_in_ready", bus.in_ready, 4'b0000);
      tick();
      check_out("bp_hold", 1'b1, 8'h5C, 2'd2);
    end
    bus.out_ready = 1'b1;
    #1 check("bp_release_ready", bus.in_ready, 4'b1000);
    tick();
    check_out("bp_nobubble", 1'b1, 8'hA3, 2'd3);

    // Reset mid-stall discards the held 77 word.
    set_data(0, 8'h77);
    bus.in_valid = 4'b0001;
    #1 check("r77_in_ready", bus.in_ready, 4'b0001);
    tick();
    check_out("r77_load", 1'b1, 8'h77, 2'd0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0000;
    tick();
    check_out("r77_stall", 1'b1, 8'h77, 2'd0);
    rst = 1'b1;
    tick();
    check_out("r77_reset", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("r77_gone", bus.out_valid, 1'b0);

    // Pointer returned to 0 by reset.
    set_data(0, 8'hA0);
    bus.in_valid = 4'hF;
    #1 check("post_rst_ready", bus.in_ready, 4'b0001);
    tick();
    check_out("post_rst_g0", 1'b1, 8'hA0, 2'd0);

    // Drain with nothing to accept: valid drops, data and select hold.
    bus.in_valid = 4'b0000;
    #1 check("drain_in_ready", bus.in_ready, 4'b0000);
    tick();
    check_out("drain", 1'b0, 8'hA0, 2'd0);
`else
    // Inputs 0 and 2 both valid: input 0 always wins.
    bus.in_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1 check("fp_in_ready", bus.in_ready, 4'b0001);
      tick();
      check_out("fp_g0", 1'b1, 8'hA0, 2'd0);
    end
    bus.in_valid = 4'b0100;
    #1 check("fp_in_ready2", bus.in_ready, 4'b0100);
    tick();
    check_out("fp_g2", 1'b1, 8'hA2, 2'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
